// File: rtl/snr_apb_pkg.sv
// Shared types and constants for the SNR APB initiator and its helpers.
// No logic; no latency.
// No flow control of its own.
package snr_apb_pkg;

  localparam int APB_ADDR_W = 10;
  localparam int APB_DATA_W = 32;

  // Word address of the SNR result register in the SNR register block
  localparam logic [APB_ADDR_W-1:0] SNR_REG_ADDR = '0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  // Counter width able to hold 0..limit; a disabled watchdog (limit 0) still gets one bit
  function automatic int cnt_width(input int limit);
    return (limit > 0) ? $clog2(limit + 1) : 1;
  endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// Saturating wait-cycle counter with clear, enable and limit-reached flag.
// at_limit reflects the registered count (same cycle as cnt_q).
// No backpressure; clear has priority over enable, count sticks at full scale.
module apb_timeout_cnt #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] limit,
  output logic             at_limit
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count: clear wins, otherwise step while enabled unless already saturated
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  // Count register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit = (cnt_q == limit);

endmodule

// File: rtl/snr_apb_master.sv
// APB3 initiator: one valid/ready request becomes one APB transfer with a held response.
// Accept at edge N: SETUP after N, ACCESS after N+1, rsp_valid after N+2 plus one per wait state.
// req_ready only in IDLE; response held until rsp_ready, no new transfer until it is consumed.
module snr_apb_master
  import snr_apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  localparam int            CW      = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] LIMIT   = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam bit            WDOG_EN = (TIMEOUT != 0);

  apb_state_e        state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;

  logic cnt_en;
  logic cnt_clr;
  logic wdog_hit;

  // Count every ACCESS cycle the responder stalls; restart once the response is taken
  assign cnt_en  = (state_q == ACCESS) && !PREADY;
  assign cnt_clr = (state_q == RESP) && rsp_ready;

  apb_timeout_cnt #(
    .WIDTH (CW)
  ) u_wdog (
    .clk      (PCLK),
    .rst      (PRESET),
    .clr      (cnt_clr),
    .en       (cnt_en),
    .limit    (LIMIT),
    .at_limit (wdog_hit)
  );

  // Transfer sequencing and response capture; bus strobes decoded from the next state
  always_comb begin
    state_d       = state_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          pwrite_d = req_write;
          paddr_d  = req_addr;
          pwdata_d = req_wdata;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
          rsp_err_d     = PSLVERR;
          rsp_timeout_d = 1'b0;
          state_d       = RESP;
        end else if (WDOG_EN && wdog_hit) begin
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          state_d       = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    psel_d      = (state_d == SETUP) || (state_d == ACCESS);
    penable_d   = (state_d == ACCESS);
    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
  end

  // All state and outputs registered together; reset aborts any transfer silently
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q       <= IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      req_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_snr_apb_master.sv
// Bench for snr_apb_master: directed table, reset abort sequence, randomized transfers.
// Latency measured in falling edges after the accepting rising edge.
// Responder stalls PREADY per transfer and holds rsp_ready low to apply backpressure.
module tb_snr_apb_master;
  import snr_apb_pkg::*;

  localparam int TO = 8;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [9:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA  = 32'h0;
  logic        PREADY  = 1'b0;
  logic        PSLVERR = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  // Responder configuration for the current transfer
  int          cur_waits = 0;
  logic [31:0] cur_rdata = 32'h0;
  logic        cur_err   = 1'b0;
  int          acc_cnt   = 0;

  typedef struct {
    logic        wr;
    logic [9:0]  addr;
    logic [31:0] wd;
    int          waits;
    logic [31:0] rd;
    logic        se;
    int          hold;
    int          exp_lat;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_to;
  } vec_t;

  vec_t tbl [6];

  always #5 PCLK = ~PCLK;

  snr_apb_master #(
    .ADDR_W  (10),
    .DATA_W  (32),
    .TIMEOUT (TO)
  ) dut (
    .PCLK        (PCLK),
    .PRESET      (PRESET),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .PSEL        (PSEL),
    .PENABLE     (PENABLE),
    .PWRITE      (PWRITE),
    .PADDR       (PADDR),
    .PWDATA      (PWDATA),
    .PRDATA      (PRDATA),
    .PREADY      (PREADY),
    .PSLVERR     (PSLVERR)
  );

  // APB responder: ready after cur_waits stalled ACCESS cycles; junk data/error while stalling
  always @(negedge PCLK) begin
    if (PSEL && PENABLE) acc_cnt = acc_cnt + 1;
    else acc_cnt = 0;
    PREADY  = PSEL && PENABLE && (acc_cnt > cur_waits);
    PRDATA  = PREADY ? cur_rdata : ~cur_rdata;
    PSLVERR = PREADY ? cur_err : 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: number of ACCESS cycles a transfer occupies
  function automatic int access_cycles(input int waits);
    return (waits + 1 <= TO) ? waits + 1 : TO;
  endfunction

  function automatic vec_t model(input vec_t v);
    vec_t r;
    bit   timed;
    r           = v;
    timed       = (v.waits + 1) > TO;
    r.exp_lat   = 2 + access_cycles(v.waits);
    r.exp_to    = timed;
    r.exp_err   = timed | v.se;
    r.exp_rdata = (timed || v.wr) ? 32'h0 : v.rd;
    return r;
  endfunction

  task automatic run_txn(input vec_t v, input string tag);
    int          k;
    int          bad;
    int          psel_n;
    int          pen_n;
    bit          got;
    logic [31:0] r_rdata;
    logic        r_err;
    logic        r_to;

    cur_waits = v.waits;
    cur_rdata = v.rd;
    cur_err   = v.se;

    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge PCLK);
      if (req_ready === 1'b1) got = 1'b1;
    end
    if (!got) begin
      chk({tag, " req_ready_wait"}, 32'(req_ready), 32'h1);
      return;
    end

    req_valid = 1'b1;
    req_write = v.wr;
    req_addr  = v.addr;
    req_wdata = v.wd;
    @(negedge PCLK);
    req_valid = 1'b0;
    req_write = ~v.wr;
    req_addr  = ~v.addr;
    req_wdata = ~v.wd;

    k = 1;
    chk({tag, " setup{psel,pen,rdy}"}, 32'({PSEL, PENABLE, req_ready}), 32'b100);

    bad = 0; psel_n = 0; pen_n = 0; got = 1'b0;
    while (k < 60 && !got) begin
      if (rsp_valid === 1'b1) begin
        got = 1'b1;
      end else begin
        if (PSEL === 1'b1) begin
          psel_n++;
          if (PADDR !== v.addr || PWDATA !== v.wd || PWRITE !== v.wr) bad++;
        end
        if (PENABLE === 1'b1) pen_n++;
        @(negedge PCLK);
        k++;
      end
    end

    chk({tag, " rsp_latency"}, 32'(k), 32'(v.exp_lat));
    chk({tag, " psel_cycles"}, 32'(psel_n), 32'(v.exp_lat - 1));
    chk({tag, " penable_cycles"}, 32'(pen_n), 32'(v.exp_lat - 2));
    chk({tag, " addr_data_stable_errs"}, 32'(bad), 32'h0);
    chk({tag, " rsp_rdata"}, rsp_rdata, v.exp_rdata);
    chk({tag, " {err,timeout,psel}"}, 32'({rsp_err, rsp_timeout, PSEL}), 32'({v.exp_err, v.exp_to, 1'b0}));

    r_rdata = rsp_rdata;
    r_err   = rsp_err;
    r_to    = rsp_timeout;

    if (v.hold > 0) begin
      bad       = 0;
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 10'h155;
      for (int i = 0; i < v.hold; i++) begin
        @(negedge PCLK);
        if (rsp_valid !== 1'b1 || rsp_rdata !== r_rdata || rsp_err !== r_err ||
            rsp_timeout !== r_to || PSEL !== 1'b0 || req_ready !== 1'b0) bad++;
      end
      chk({tag, " backpressure_errs"}, 32'(bad), 32'h0);
    end

    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge PCLK);
    rsp_ready = 1'b0;
    chk({tag, " release{vld,rdy,psel}"}, 32'({rsp_valid, req_ready, PSEL}), 32'b010);
  endtask

  initial begin
    #300000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    vec_t v;
    int   bad;

    //            wr    addr          wd            waits rd            se    hold lat rdata         err   to
    tbl[0] = '{1'b0, SNR_REG_ADDR, 32'h0,        0,  32'h0001_2345, 1'b0, 0,  3, 32'h0001_2345, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 10'h004,      32'hDEAD_BEEF, 2, 32'h1111_1111, 1'b0, 0,  5, 32'h0,         1'b0, 1'b0};
    tbl[2] = '{1'b0, 10'h010,      32'h0,        30, 32'h2222_2222, 1'b0, 0, 10, 32'h0,         1'b1, 1'b1};
    tbl[3] = '{1'b1, 10'h020,      32'hA5A5_A5A5, 7, 32'h3333_3333, 1'b1, 0, 10, 32'h0,         1'b1, 1'b0};
    tbl[4] = '{1'b0, 10'h008,      32'h0,         0, 32'h0000_55AA, 1'b0, 5,  3, 32'h0000_55AA, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 10'h00C,      32'h0,         1, 32'hCAFE_0001, 1'b1, 0,  4, 32'hCAFE_0001, 1'b1, 1'b0};

    PRESET    = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge PCLK);
    PRESET = 1'b0;

    chk("reset {psel,pen,pwr,rdy,vld,err,to}",
        32'({PSEL, PENABLE, PWRITE, req_ready, rsp_valid, rsp_err, rsp_timeout}), 32'b0001000);
    chk("reset paddr", 32'(PADDR), 32'h0);
    chk("reset pwdata", PWDATA, 32'h0);
    chk("reset rsp_rdata", rsp_rdata, 32'h0);

    for (int i = 0; i < 6; i++) begin
      run_txn(tbl[i], $sformatf("vec%0d", i));
    end

    // Reset during ACCESS: abort without a response, then a normal read
    cur_waits = 100;
    cur_rdata = 32'h7777_0000;
    cur_err   = 1'b0;
    @(negedge PCLK);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 10'h3FF;
    req_wdata = 32'h1234_5678;
    @(negedge PCLK);
    req_valid = 1'b0;
    repeat (3) @(negedge PCLK);
    chk("rst_mid {psel,pen} before", 32'({PSEL, PENABLE}), 32'b11);
    PRESET = 1'b1;
    @(negedge PCLK);
    PRESET = 1'b0;
    chk("rst_mid {psel,pen,pwr,rdy,vld,err,to}",
        32'({PSEL, PENABLE, PWRITE, req_ready, rsp_valid, rsp_err, rsp_timeout}), 32'b0001000);
    chk("rst_mid paddr", 32'(PADDR), 32'h0);
    chk("rst_mid pwdata", PWDATA, 32'h0);
    chk("rst_mid rsp_rdata", rsp_rdata, 32'h0);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge PCLK);
      if (rsp_valid !== 1'b0 || PSEL !== 1'b0) bad++;
    end
    chk("rst_mid no_rsp_errs", 32'(bad), 32'h0);
    v = '{1'b0, 10'h001, 32'h0, 6, 32'h0BAD_F00D, 1'b0, 0, 0, 32'h0, 1'b0, 1'b0};
    run_txn(model(v), "post_rst");

    // Randomized transfers against the reference model
    for (int i = 0; i < 40; i++) begin
      v.wr    = 1'($urandom_range(0, 1));
      v.addr  = 10'($urandom);
      v.wd    = $urandom;
      v.waits = int'($urandom_range(0, 10));
      v.rd    = $urandom;
      v.se    = ($urandom_range(0, 3) == 0);
      v.hold  = int'($urandom_range(0, 3));
      run_txn(model(v), $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
